// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: datapath and index widths, ALU op codes,
// the ID/EX register bundle and a small dependency-match helper.
package rv32im_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int ALU_SW = 5;

  localparam logic [ALU_SW-1:0] ALU_ADD    = 5'b00000;
  localparam logic [ALU_SW-1:0] ALU_MUL    = 5'b01000;
  localparam logic [ALU_SW-1:0] ALU_MULH   = 5'b01001;
  localparam logic [ALU_SW-1:0] ALU_MULHSU = 5'b01010;
  localparam logic [ALU_SW-1:0] ALU_MULHU  = 5'b01011;
  localparam logic [ALU_SW-1:0] ALU_DIV    = 5'b01100;
  localparam logic [ALU_SW-1:0] ALU_DIVU   = 5'b01101;
  localparam logic [ALU_SW-1:0] ALU_REM    = 5'b01110;
  localparam logic [ALU_SW-1:0] ALU_REMU   = 5'b01111;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [ALU_SW-1:0] select;
    logic              op1_pc;
    logic              op2_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_regs_t;

  // A writer at index rd satisfies a reader of src; x0 never counts.
  function automatic logic src_hit(input logic en,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] src);
    return en && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded fields from ID, pipeline control, forwarding
// sources from EX/MEM and MEM/WB, and the EX-side outputs to the ALU.
interface id_ex_stage_if;
  import rv32im_pkg::*;

  logic              ID_VALID;
  logic [XLEN-1:0]   ID_PC;
  logic [XLEN-1:0]   ID_RS1_DATA;
  logic [XLEN-1:0]   ID_RS2_DATA;
  logic [XLEN-1:0]   ID_IMM;
  logic [REG_AW-1:0] ID_RS1_ADDR;
  logic [REG_AW-1:0] ID_RS2_ADDR;
  logic [REG_AW-1:0] ID_RD_ADDR;
  logic              ID_USES_RS1;
  logic              ID_USES_RS2;
  logic [ALU_SW-1:0] ID_ALU_SELECT;
  logic              ID_OP1_PC;
  logic              ID_OP2_IMM;
  logic              ID_REG_WRITE;
  logic              ID_MEM_READ;
  logic              ID_MEM_WRITE;
  logic              HOLD;
  logic              FLUSH;
  logic [REG_AW-1:0] MEM_RD_ADDR;
  logic [REG_AW-1:0] WB_RD_ADDR;
  logic              MEM_REG_WRITE;
  logic              WB_REG_WRITE;
  logic [XLEN-1:0]   MEM_RESULT;
  logic [XLEN-1:0]   WB_RESULT;

  logic [XLEN-1:0]   DATA1;
  logic [XLEN-1:0]   DATA2;
  logic [ALU_SW-1:0] SELECT;
  logic [XLEN-1:0]   EX_STORE_DATA;
  logic              EX_VALID;
  logic              EX_REG_WRITE;
  logic              EX_MEM_READ;
  logic              EX_MEM_WRITE;
  logic [REG_AW-1:0] EX_RD_ADDR;
  logic [XLEN-1:0]   EX_PC;
  logic              LOAD_STALL;

  modport master (
    output ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
           ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_USES_RS1, ID_USES_RS2,
           ID_ALU_SELECT, ID_OP1_PC, ID_OP2_IMM, ID_REG_WRITE, ID_MEM_READ,
           ID_MEM_WRITE, HOLD, FLUSH, MEM_RD_ADDR, WB_RD_ADDR, MEM_REG_WRITE,
           WB_REG_WRITE, MEM_RESULT, WB_RESULT,
    input  DATA1, DATA2, SELECT, EX_STORE_DATA, EX_VALID, EX_REG_WRITE,
           EX_MEM_READ, EX_MEM_WRITE, EX_RD_ADDR, EX_PC, LOAD_STALL
  );

  modport slave (
    input  ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
           ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_USES_RS1, ID_USES_RS2,
           ID_ALU_SELECT, ID_OP1_PC, ID_OP2_IMM, ID_REG_WRITE, ID_MEM_READ,
           ID_MEM_WRITE, HOLD, FLUSH, MEM_RD_ADDR, WB_RD_ADDR, MEM_REG_WRITE,
           WB_REG_WRITE, MEM_RESULT, WB_RESULT,
    output DATA1, DATA2, SELECT, EX_STORE_DATA, EX_VALID, EX_REG_WRITE,
           EX_MEM_READ, EX_MEM_WRITE, EX_RD_ADDR, EX_PC, LOAD_STALL
  );

endinterface

// File: rtl/fwd_unit.sv
// Combinational operand forwarding for one source register: EX/MEM beats
// MEM/WB, which beats the register-file value registered in ID/EX.
module fwd_unit
  import rv32im_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]   wb_result_i,
  output logic [XLEN-1:0]   fwd_data_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = src_hit(mem_reg_write_i, mem_rd_addr_i, src_addr_i);
  assign wb_hit  = src_hit(wb_reg_write_i, wb_rd_addr_i, src_addr_i);

  always_comb begin
    fwd_data_o = rf_data_i;
    if (mem_hit) begin
      fwd_data_o = mem_result_i;
    end else if (wb_hit) begin
      fwd_data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble
// insertion; drives the ALU operands and the EX/MEM control bits.
module id_ex_stage
  import rv32im_pkg::*;
(
  input logic         CLK,
  input logic         RESET_N,
  id_ex_stage_if.slave bus
);

  ex_regs_t        ex_q;
  ex_regs_t        ex_d;
  ex_regs_t        id_fields;
  logic            load_stall;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    id_fields           = '0;
    id_fields.valid     = bus.ID_VALID;
    id_fields.pc        = bus.ID_PC;
    id_fields.rs1_data  = bus.ID_RS1_DATA;
    id_fields.rs2_data  = bus.ID_RS2_DATA;
    id_fields.imm       = bus.ID_IMM;
    id_fields.rs1_addr  = bus.ID_RS1_ADDR;
    id_fields.rs2_addr  = bus.ID_RS2_ADDR;
    id_fields.rd_addr   = bus.ID_RD_ADDR;
    id_fields.select    = bus.ID_ALU_SELECT;
    id_fields.op1_pc    = bus.ID_OP1_PC;
    id_fields.op2_imm   = bus.ID_OP2_IMM;
    id_fields.reg_write = bus.ID_REG_WRITE;
    id_fields.mem_read  = bus.ID_MEM_READ;
    id_fields.mem_write = bus.ID_MEM_WRITE;
  end

  // A load in EX whose rd feeds the instruction in ID cannot be forwarded yet.
  assign load_stall = ex_q.valid && ex_q.mem_read && !bus.FLUSH && !bus.HOLD &&
                      ((bus.ID_USES_RS1 && src_hit(1'b1, ex_q.rd_addr, bus.ID_RS1_ADDR)) ||
                       (bus.ID_USES_RS2 && src_hit(1'b1, ex_q.rd_addr, bus.ID_RS2_ADDR)));

  always_comb begin
    ex_d = id_fields;
    if (bus.FLUSH) begin
      ex_d = '0;
    end else if (bus.HOLD) begin
      ex_d = ex_q;
    end else if (load_stall) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_unit u_fwd_rs1 (
    .src_addr_i      (ex_q.rs1_addr),
    .rf_data_i       (ex_q.rs1_data),
    .mem_reg_write_i (bus.MEM_REG_WRITE),
    .mem_rd_addr_i   (bus.MEM_RD_ADDR),
    .mem_result_i    (bus.MEM_RESULT),
    .wb_reg_write_i  (bus.WB_REG_WRITE),
    .wb_rd_addr_i    (bus.WB_RD_ADDR),
    .wb_result_i     (bus.WB_RESULT),
    .fwd_data_o      (rs1_fwd)
  );

  fwd_unit u_fwd_rs2 (
    .src_addr_i      (ex_q.rs2_addr),
    .rf_data_i       (ex_q.rs2_data),
    .mem_reg_write_i (bus.MEM_REG_WRITE),
    .mem_rd_addr_i   (bus.MEM_RD_ADDR),
    .mem_result_i    (bus.MEM_RESULT),
    .wb_reg_write_i  (bus.WB_REG_WRITE),
    .wb_rd_addr_i    (bus.WB_RD_ADDR),
    .wb_result_i     (bus.WB_RESULT),
    .fwd_data_o      (rs2_fwd)
  );

  assign bus.DATA1         = ex_q.op1_pc  ? ex_q.pc  : rs1_fwd;
  assign bus.DATA2         = ex_q.op2_imm ? ex_q.imm : rs2_fwd;
  assign bus.EX_STORE_DATA = rs2_fwd;
  assign bus.SELECT        = ex_q.select;
  assign bus.EX_VALID      = ex_q.valid;
  assign bus.EX_REG_WRITE  = ex_q.reg_write;
  assign bus.EX_MEM_READ   = ex_q.mem_read;
  assign bus.EX_MEM_WRITE  = ex_q.mem_write;
  assign bus.EX_RD_ADDR    = ex_q.rd_addr;
  assign bus.EX_PC         = ex_q.pc;
  assign bus.LOAD_STALL    = load_stall;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the RV32IM pipelined core. It registers decoded instruction fields from ID and resolves operand forwarding from the EX/MEM and MEM/WB stages. It detects load-use hazards, inserting bubbles and requesting an upstream stall. It drives the `alu` inputs `DATA1`, `DATA2` and `SELECT` directly, and carries the control bits that EX/MEM needs.

## Interface
- `XLEN`, 32, datapath width
- `CLK`  in  1  rising-edge clock
- `RESET_N`  in  1  asynchronous, active-low reset
- `ID_VALID`  in  1  ID holds a real instruction
- `ID_PC`  in  XLEN  instruction PC
- `ID_RS1_DATA`, `ID_RS2_DATA`  in  XLEN  register-file read data
- `ID_IMM`  in  XLEN  sign-extended immediate
- `ID_RS1_ADDR`, `ID_RS2_ADDR`, `ID_RD_ADDR`  in  5  register indices
- `ID_USES_RS1`, `ID_USES_RS2`  in  1  instruction reads rs1/rs2
- `ID_ALU_SELECT`  in  5  ALU op code, 00000 ADD … 01111 REMU
- `ID_OP1_PC`  in  1  operand 1 = PC (AUIPC/JAL)
- `ID_OP2_IMM`  in  1  operand 2 = immediate
- `ID_REG_WRITE`, `ID_MEM_READ`, `ID_MEM_WRITE`  in  1  control bits
- `HOLD`  in  1  downstream memory stall; freeze stage
- `FLUSH`  in  1  taken branch/jump; kill the instruction entering EX
- `MEM_RD_ADDR`, `WB_RD_ADDR`  in  5  destinations in EX/MEM and MEM/WB
- `MEM_REG_WRITE`, `WB_REG_WRITE`  in  1  those stages write rd
- `MEM_RESULT`, `WB_RESULT`  in  XLEN  forwardable values
- `DATA1`, `DATA2`  out  XLEN  ALU operands
- `SELECT`  out  5  ALU op
- `EX_STORE_DATA`  out  XLEN  forwarded rs2 for stores
- `EX_VALID`, `EX_REG_WRITE`, `EX_MEM_READ`, `EX_MEM_WRITE`  out  1
- `EX_RD_ADDR`  out  5; `EX_PC`  out  XLEN
- `LOAD_STALL`  out  1  hold PC and IF/ID this cycle

## Operation
- Each cycle, the stage registers all `ID_*` fields into EX registers. Registered `ID_RS1_ADDR` and `ID_RS2_ADDR` are kept for forwarding.
- Register-update priority: reset > `FLUSH` > `HOLD` > load-use bubble > normal load.
- A bubble sets valid, REG_WRITE, MEM_READ and MEM_WRITE to 0, `SELECT` to 00000, and the data fields to 0.
- `HOLD` keeps every EX register unchanged.
- Load-use detection:
  - `LOAD_STALL = EX_VALID & EX_MEM_READ & EX_RD_ADDR!=0 & ((ID_USES_RS1 & ID_RS1_ADDR==EX_RD_ADDR) | (ID_USES_RS2 & ID_RS2_ADDR==EX_RD_ADDR)) & !FLUSH & !HOLD`.
  - On `LOAD_STALL` the stage loads a bubble. IF/ID holds externally, so the dependent instruction re-presents next cycle.
- Forwarding, applied per source:
  - If `MEM_REG_WRITE` is set and `MEM_RD_ADDR` is nonzero and matches the source, use `MEM_RESULT`.
  - Otherwise, if the same holds for WB, use `WB_RESULT`.
  - Otherwise use the registered register-file data.
  - MEM/WB wins over nothing; EX/MEM wins over MEM/WB. x0 is never forwarded.
- Operand selection:
  - `DATA1` = `EX_PC` if OP1_PC, else forwarded rs1.
  - `DATA2` = registered imm if OP2_IMM, else forwarded rs2.
  - `EX_STORE_DATA` = forwarded rs2, regardless of OP2_IMM.
- Widths: all compares are 5-bit equality. There is no arithmetic in this block.

## Timing
- Reset (async assert, synchronous release on `CLK`): every registered output is 0, `SELECT`=00000, and `EX_VALID`=0.
  - `DATA1`/`DATA2`/`EX_STORE_DATA` then evaluate to 0, unless forwarding inputs match x1–x31. They cannot match, because the registered addresses are 0.
- Latency: ID fields sampled at edge k appear on EX outputs after edge k. The ALU result is available the same cycle, combinationally in `alu`.
- The forwarding path is purely combinational from the `MEM_*`/`WB_*` inputs to `DATA1`/`DATA2`, with zero cycles of delay.
- `LOAD_STALL` is combinational, valid in the same cycle, and lasts exactly one cycle per load-use pair. Back-to-back loads into the same consumer still produce one bubble per dependent instruction.
- `FLUSH` and `LOAD_STALL` in the same cycle: flush wins, and `LOAD_STALL` is 0.
- `HOLD` and `FLUSH` together: bubble loaded (flush wins).
- Reset mid-stall clears the bubble state; no residual stall follows.

## Structure
- Shared package `rv32im_pkg`: ALU select constants (ALU_ADD=5'b00000 … ALU_REMU=5'b01111), `XLEN`, and register-index width.
- One sub-module, `fwd_unit`: purely combinational, instantiated twice (rs1, rs2). It takes an address, register-file data and the MEM/WB pairs, and returns the forwarded value.

## Test plan
- Reset asserted mid-run with `ID_VALID`=1 → all EX outputs 0 immediately, `EX_VALID`=0; the first post-release edge loads ID fields.
- ADD x3,x1,x2 with `MEM_RD_ADDR`=1, `MEM_RESULT`=5, `WB_RD_ADDR`=2, `WB_RESULT`=9 → `DATA1`=5, `DATA2`=9, `SELECT`=00000. The ALU gives 14.
- Both MEM and WB target x1 (MEM=7, WB=3) → `DATA1`=7. With rd=x0 and `MEM_RESULT`=7 → `DATA1` = register-file value, not 7.
- LW x4 in EX, ID instruction MUL using rs2=x4 → `LOAD_STALL`=1 for one cycle, next EX is a bubble (`SELECT`=0, `EX_REG_WRITE`=0). After that the MUL enters with `SELECT`=01000.
- `FLUSH` together with a load-use hazard → `LOAD_STALL`=0, bubble loaded. `HOLD` for 3 cycles → EX outputs are stable across all 3 edges.
- ADDI with OP2_IMM and `ID_IMM`=0xFFFFFFFF; store with forwarded rs2=0x1234 → `DATA2`=0xFFFFFFFF for the ADDI. For the store, `DATA2`=immediate and `EX_STORE_DATA`=0x1234.
